la_clkdiv: RTL and testbench

- Programmable integer clock divider.
- Takes one source clock and derives a glitch-free divided clock plus single-cycle rise/fall strobes in the source domain.
- Decomposes a clock into slower clocks and clock-enables, as opposed to combining clocks.
- Sits in clock-generation logic ahead of clock gates and clock-OR cells; strobes serve as enables for logic kept on the source clock.

---
 rtl/la_clkdiv.sv | 123 ++++++++++++
 tb/tb_la_clkdiv.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/la_clkdiv.sv
// la_clkdiv: programmable integer clock divider with source-domain rise/fall strobes; LA_CLKDIV_ODD50_EN adds a negedge flop for 50% duty on odd ratios.
// Latency: en sampled in IDLE drives clkout high on the next clk edge; stop requests and div changes take effect only at period boundaries.
// Backpressure: none; en and div are level requests with no handshake, and a period is never truncated.
module la_clkdiv #(
    parameter     PROP = "DEFAULT",
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          en,
    input  logic [DW-1:0] div,
    output logic          clkout,
    output logic          rise,
    output logic          fall,
    output logic          active
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] divreg_q, divreg_d;
    logic          hi_q, hi_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    logic          div_ok;
    logic          at_boundary;
    logic [DW-1:0] cnt_inc;
    logic [DW-1:0] half;
    logic          unused_prop;

    assign unused_prop = |PROP;

    // Ratios 0 and 1 both mean stop, so any set bit above bit 0 is a valid ratio.
    assign div_ok      = |div[DW-1:1];
    assign cnt_inc     = cnt_q + DW'(1);
    assign half        = divreg_q >> 1;
    assign at_boundary = (cnt_q == (divreg_q - DW'(1)));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        divreg_d = divreg_q;
        hi_d     = 1'b0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && div_ok) begin
                    state_d  = RUN;
                    divreg_d = div;
                    cnt_d    = '0;
                    hi_d     = 1'b1;
                    rise_d   = 1'b1;
                end
            end
            RUN: begin
                if (!at_boundary) begin
                    cnt_d  = cnt_inc;
                    hi_d   = (cnt_inc < half);
                    fall_d = hi_q && !hi_d;
                end else if (en && div_ok) begin
                    // div is only sampled here, so mid-period changes cannot shorten a pulse.
                    divreg_d = div;
                    cnt_d    = '0;
                    hi_d     = 1'b1;
                    rise_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            divreg_q <= '0;
            hi_q     <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            divreg_q <= divreg_d;
            hi_q     <= hi_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign rise   = rise_q;
    assign fall   = fall_q;
    assign active = (state_q == RUN);

`ifdef LA_CLKDIV_ODD50_EN
    logic neg_q;

    // Trails hi_q by half a cycle; OR-ing it in stretches odd high phases without a gap.
    always_ff @(negedge clk or negedge nreset) begin
        if (!nreset) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= hi_q;
        end
    end

    assign clkout = hi_q | (neg_q & divreg_q[0]);
`else
    assign clkout = hi_q;
`endif

endmodule

// File: tb/tb_la_clkdiv.sv
// Directed table-driven bench for la_clkdiv plus hand sequences for reset, odd duty and max ratio.
module tb_la_clkdiv;

`ifdef LA_CLKDIV_ODD50_EN
    localparam bit ODD50 = 1'b1;
`else
    localparam bit ODD50 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       nreset;
    logic       en;
    logic [7:0] div;
    logic       clkout;
    logic       rise;
    logic       fall;
    logic       active;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    la_clkdiv #(.PROP("DEFAULT"), .DW(8)) dut (
        .clk    (clk),
        .nreset (nreset),
        .en     (en),
        .div    (div),
        .clkout (clkout),
        .rise   (rise),
        .fall   (fall),
        .active (active)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rise && fall) overlap++;
    end

    typedef struct {
        logic       en;
        logic [7:0] div;
        logic       clkout;
        logic       rise;
        logic       fall;
        logic       active;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic e, input logic [7:0] d, input logic c,
                       input logic r, input logic f, input logic a);
        vec_t v;
        v.en = e; v.div = d; v.clkout = c; v.rise = r; v.fall = f; v.active = a;
        tbl.push_back(v);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic c, input logic r,
                             input logic f, input logic a);
        check_bit({name, "_clkout"}, clkout, c);
        check_bit({name, "_rise"}, rise, r);
        check_bit({name, "_fall"}, fall, f);
        check_bit({name, "_active"}, active, a);
    endtask

    initial begin
        logic exp_edge[6];
        int   highs;
        int   rises;
        int   falls;
        int   waited;

        // div=4 run, two periods
        add(1, 4, 1, 1, 0, 1); add(1, 4, 1, 0, 0, 1); add(1, 4, 0, 0, 1, 1); add(1, 4, 0, 0, 0, 1);
        add(1, 4, 1, 1, 0, 1); add(1, 4, 1, 0, 0, 1); add(1, 4, 0, 0, 1, 1); add(1, 4, 0, 0, 0, 1);
        // div changed to 6 at cnt=1: current period stays 4, next is 3 high / 3 low
        add(1, 4, 1, 1, 0, 1); add(1, 4, 1, 0, 0, 1); add(1, 6, 0, 0, 1, 1); add(1, 6, 0, 0, 0, 1);
        add(1, 6, 1, 1, 0, 1); add(1, 6, 1, 0, 0, 1); add(1, 6, 1, 0, 0, 1);
        add(1, 6, 0, 0, 1, 1); add(1, 6, 0, 0, 0, 1); add(1, 6, 0, 0, 0, 1);
        // div=8, en dropped at cnt=2: period completes, then IDLE
        add(1, 8, 1, 1, 0, 1); add(1, 8, 1, 0, 0, 1); add(1, 8, 1, 0, 0, 1); add(0, 8, 1, 0, 0, 1);
        add(0, 8, 0, 0, 1, 1); add(0, 8, 0, 0, 0, 1); add(0, 8, 0, 0, 0, 1); add(0, 8, 0, 0, 0, 1);
        add(0, 8, 0, 0, 0, 0); add(0, 8, 0, 0, 0, 0);
        // div=2 toggles, then div=4 with en 1->0->1 inside one period
        add(1, 2, 1, 1, 0, 1); add(1, 2, 0, 0, 1, 1); add(1, 2, 1, 1, 0, 1); add(1, 2, 0, 0, 1, 1);
        add(1, 4, 1, 1, 0, 1); add(0, 4, 1, 0, 0, 1); add(1, 4, 0, 0, 1, 1); add(1, 4, 0, 0, 0, 1);
        add(1, 4, 1, 1, 0, 1);
        // div forced to 0/1 while running: stop at boundary; 0/1 from IDLE never start
        add(1, 0, 1, 0, 0, 1); add(1, 0, 0, 0, 1, 1); add(1, 1, 0, 0, 0, 1); add(1, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0); add(1, 1, 0, 0, 0, 0); add(0, 3, 0, 0, 0, 0);
        // div=3: high 1 / low 2 at posedge samples (negedge flop extends the first low sample)
        add(1, 3, 1, 1, 0, 1); add(1, 3, ODD50, 0, 1, 1); add(1, 3, 0, 0, 0, 1); add(0, 3, 0, 0, 0, 0);

        nreset = 1'b0;
        en     = 1'b0;
        div    = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        nreset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            en  = tbl[i].en;
            div = tbl[i].div;
            step();
            check_all($sformatf("row%0d", i), tbl[i].clkout, tbl[i].rise, tbl[i].fall, tbl[i].active);
        end

        // Async reset mid-period with clkout high, then restart at div=2
        en  = 1'b1;
        div = 8'd4;
        step();
        step();
        check_bit("pre_reset_clkout", clkout, 1'b1);
        #2;
        nreset = 1'b0;
        #1;
        check_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        div = 8'd2;
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_all($sformatf("div2_after_reset%0d", i), (i % 2) == 0, (i % 2) == 0, (i % 2) == 1, 1'b1);
        end
        en = 1'b0;
        step();
        check_all("div2_stop", 1'b0, 1'b0, 1'b0, 1'b0);

        // div=3 observed on both edges: high phase 1 or 1.5 clk
        exp_edge[0] = 1'b1; exp_edge[1] = 1'b1; exp_edge[2] = ODD50;
        exp_edge[3] = 1'b0; exp_edge[4] = 1'b0; exp_edge[5] = 1'b0;
        en  = 1'b1;
        div = 8'd3;
        @(posedge clk);
        #1;
        en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_bit($sformatf("div3_edge%0d", i), clkout, exp_edge[i]);
            if (i < 5) begin
                if ((i % 2) == 0) @(negedge clk);
                else @(posedge clk);
                #1;
            end
        end
        step();
        check_bit("div3_idle_active", active, 1'b0);

        // div=255: period 255, 127 high posedge samples (128 with the negedge flop)
        en  = 1'b1;
        div = 8'd255;
        highs = 0;
        rises = 0;
        falls = 0;
        for (int i = 0; i < 255; i++) begin
            step();
            if (clkout) highs++;
            if (rise) rises++;
            if (fall) falls++;
        end
        check_int("div255_high_cycles", highs, 127 + int'(ODD50));
        check_int("div255_rises", rises, 1);
        check_int("div255_falls", falls, 1);
        step();
        check_bit("div255_next_rise", rise, 1'b1);
        en = 1'b0;
        waited = 0;
        while (active && waited < 300) begin
            step();
            waited++;
        end
        check_int("div255_stop_cycles", waited, 255);
        check_bit("div255_stopped_clkout", clkout, 1'b0);

        check_int("rise_fall_overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
